game_timebase: RTL

Parametrised timebase generator feeding the snake game core and the VGA graphics pipeline from the 100 MHz board clock. It produces the pixel strobe through a phase accumulator and a game-move tick whose period shortens with a speed level. The move tick supports pause and single-step, and a heartbeat output toggles on every tick. It replaces the ad-hoc divider logic in the top level and drives the `move_clk`/`pix_stb` inputs of the game and graphics blocks.

---
 rtl/game_timebase_pkg.sv | 27 ++
 rtl/game_timebase_pix_strobe_gen.sv | 29 ++
 rtl/game_timebase.sv | 133 +++++++++++++
 3 files changed

// File: rtl/game_timebase_pkg.sv
// Shared types and helpers for the game timebase: FSM state, move-period
// arithmetic and the simulation-speedup scaling used by GAME_TIMEBASE_SIM_FAST_EN.
package game_timebase_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } tb_state_t;

  localparam int unsigned SIM_FAST_SHIFT = 16;

  function automatic int unsigned period_for_level(
    input int unsigned base,
    input int unsigned step,
    input int unsigned level
  );
    return base - level * step;
  endfunction

  // Shrinks a clock count for fast simulation while keeping it non-zero.
  function automatic int unsigned sim_fast_scale(input int unsigned value);
    int unsigned shifted;
    shifted = value >> SIM_FAST_SHIFT;
    return (shifted == 0) ? 1 : shifted;
  endfunction

endpackage

// File: rtl/game_timebase_pix_strobe_gen.sv
// Phase-accumulator strobe generator: pix_stb_o is the registered carry out of
// acc + PIX_INC, giving a strobe rate of f_clk * PIX_INC / 2^PIX_ACC_W.
module pix_strobe_gen
  import game_timebase_pkg::*;
#(
  parameter int unsigned               PIX_ACC_W = 16,
  parameter logic [PIX_ACC_W-1:0]      PIX_INC   = 16'h4000
) (
  input  logic CLK,
  input  logic RST_BTN_N,
  output logic pix_stb_o
);

  logic [PIX_ACC_W-1:0] acc_reg;
  logic [PIX_ACC_W:0]   sum_next;

  assign sum_next = {1'b0, acc_reg} + {1'b0, PIX_INC};

  always_ff @(posedge CLK or negedge RST_BTN_N) begin
    if (!RST_BTN_N) begin
      acc_reg   <= '0;
      pix_stb_o <= 1'b0;
    end else begin
      acc_reg   <= sum_next[PIX_ACC_W-1:0];
      pix_stb_o <= sum_next[PIX_ACC_W];
    end
  end

endmodule

// File: rtl/game_timebase.sv
// Timebase for the snake game: pixel strobe plus a level-dependent move tick with
// pause/single-step and heartbeat. Define GAME_TIMEBASE_SIM_FAST_EN to shrink move periods.
module game_timebase
  import game_timebase_pkg::*;
#(
  parameter int unsigned          PIX_ACC_W   = 16,
  parameter logic [PIX_ACC_W-1:0] PIX_INC     = 16'h4000,
  parameter int unsigned          MOVE_CNT_W  = 25,
  parameter int unsigned          BASE_PERIOD = 6_208_544,
  parameter int unsigned          PERIOD_STEP = 500_000,
  parameter int unsigned          NUM_LEVELS  = 8,
  parameter int unsigned          LEVEL_W     = $clog2(NUM_LEVELS)
) (
  input  logic               CLK,
  input  logic               RST_BTN_N,
  input  logic               pause_i,
  input  logic               step_i,
  input  logic               speed_up_i,
  input  logic               level_clr_i,
  output logic               pix_stb_o,
  output logic               move_tick_o,
  output logic               heartbeat_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               paused_o
);

`ifdef GAME_TIMEBASE_SIM_FAST_EN
  localparam int unsigned EFF_BASE = sim_fast_scale(BASE_PERIOD);
  localparam int unsigned EFF_STEP = sim_fast_scale(PERIOD_STEP);
`else
  localparam int unsigned EFF_BASE = BASE_PERIOD;
  localparam int unsigned EFF_STEP = PERIOD_STEP;
`endif

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(NUM_LEVELS - 1);

  if (NUM_LEVELS < 2) begin : g_chk_levels
    $error("game_timebase: NUM_LEVELS must be at least 2");
  end
  if (!(BASE_PERIOD > (NUM_LEVELS - 1) * PERIOD_STEP)) begin : g_chk_base
    $error("game_timebase: BASE_PERIOD must exceed (NUM_LEVELS-1)*PERIOD_STEP");
  end
  if (!(EFF_BASE > (NUM_LEVELS - 1) * EFF_STEP)) begin : g_chk_eff_base
    $error("game_timebase: scaled BASE_PERIOD must exceed (NUM_LEVELS-1)*PERIOD_STEP");
  end
  if (!(64'(BASE_PERIOD) < (64'd1 << MOVE_CNT_W))) begin : g_chk_width
    $error("game_timebase: BASE_PERIOD does not fit in MOVE_CNT_W bits");
  end

  pix_strobe_gen #(
    .PIX_ACC_W (PIX_ACC_W),
    .PIX_INC   (PIX_INC)
  ) u_pix_strobe_gen (
    .CLK       (CLK),
    .RST_BTN_N (RST_BTN_N),
    .pix_stb_o (pix_stb_o)
  );

  // Terminal count (period-1) per level, resolved at elaboration.
  logic [MOVE_CNT_W-1:0] period_m1 [NUM_LEVELS];

  for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_period
    assign period_m1[gi] = MOVE_CNT_W'(period_for_level(EFF_BASE, EFF_STEP, gi) - 1);
  end

  tb_state_t             state_reg, state_next;
  logic [MOVE_CNT_W-1:0] cnt_reg, cnt_next;
  logic [LEVEL_W-1:0]    level_reg, level_next;
  logic                  tick_reg, tick_next;
  logic                  hb_reg;

  always_ff @(posedge CLK or negedge RST_BTN_N) begin
    if (!RST_BTN_N) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      level_reg <= '0;
      tick_reg  <= 1'b0;
      hb_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      tick_reg  <= tick_next;
      hb_reg    <= hb_reg ^ tick_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    tick_next  = 1'b0;
    level_next = level_reg;

    case (state_reg)
      RUN: begin
        // The pause cycle itself neither counts nor ticks.
        if (pause_i) begin
          state_next = PAUSED;
        end else if (cnt_reg >= period_m1[level_reg]) begin
          cnt_next  = '0;
          tick_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PAUSED: begin
        if (step_i) begin
          cnt_next  = '0;
          tick_next = 1'b1;
        end
        if (!pause_i) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase

    // Clear outranks speed-up and step, and restarts the move period.
    if (level_clr_i) begin
      level_next = '0;
      cnt_next   = '0;
      tick_next  = 1'b0;
    end else if (speed_up_i && (level_reg != LEVEL_MAX)) begin
      level_next = level_reg + 1'b1;
    end
  end

  assign move_tick_o = tick_reg;
  assign heartbeat_o = hb_reg;
  assign level_o     = level_reg;
  assign paused_o    = (state_reg == PAUSED);

endmodule
